// File: rtl/mux_rr_pipe.sv
// N-channel registered multiplexer with per-channel valid/ready. Grant is either an
// explicit channel select or round-robin among valid channels; one output register stage.
module mux_rr_pipe #(
    parameter int WIDTH = 5,
    parameter int N     = 2,
    parameter int SEL_W = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_chan,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] out_data_r;
    logic [SEL_W-1:0] out_chan_r;
    logic             out_valid_r;
    logic [SEL_W-1:0] ptr_r;

    logic             load_s;
    logic             grant_valid_s;
    logic [SEL_W-1:0] grant_s;
    logic [WIDTH-1:0] grant_data_s;
    logic [SEL_W-1:0] ptr_next_s;
    logic [N-1:0]     in_ready_s;

    // Channel visited at scan offset k when the round-robin search starts at p.
    function automatic int rr_index(input logic [SEL_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        return (s >= N) ? (s - N) : s;
    endfunction

    // Grant selection: explicit select (out-of-range sel never grants) or rotating scan.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_s       = {SEL_W{1'b0}};
        grant_data_s  = {WIDTH{1'b0}};
        if (mode == 1'b0) begin
            for (int i = 0; i < N; i++) begin
                if (!grant_valid_s && (sel == SEL_W'(i)) && in_valid[i]) begin
                    grant_valid_s = 1'b1;
                    grant_s       = SEL_W'(i);
                    grant_data_s  = in_data[i*WIDTH +: WIDTH];
                end else begin
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                for (int i = 0; i < N; i++) begin
                    if (!grant_valid_s && in_valid[i] && (rr_index(ptr_r, k) == i)) begin
                        grant_valid_s = 1'b1;
                        grant_s       = SEL_W'(i);
                        grant_data_s  = in_data[i*WIDTH +: WIDTH];
                    end else begin
                    end
                end
            end
        end
    end

    // Handshake: output register free or draining, one-hot ready to the granted channel.
    always_comb begin
        load_s     = !out_valid_r || out_ready;
        in_ready_s = {N{1'b0}};
        if (grant_s == SEL_W'(N - 1)) begin
            ptr_next_s = {SEL_W{1'b0}};
        end else begin
            ptr_next_s = grant_s + SEL_W'(1);
        end
        for (int i = 0; i < N; i++) begin
            if (!rst && load_s && grant_valid_s && (grant_s == SEL_W'(i))) begin
                in_ready_s[i] = 1'b1;
            end else begin
                in_ready_s[i] = 1'b0;
            end
        end
    end

    // Output register and round-robin pointer; pointer follows grants in both modes.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_r  <= {WIDTH{1'b0}};
            out_chan_r  <= {SEL_W{1'b0}};
            out_valid_r <= 1'b0;
            ptr_r       <= {SEL_W{1'b0}};
        end else if (load_s) begin
            if (grant_valid_s) begin
                out_data_r  <= grant_data_s;
                out_chan_r  <= grant_s;
                out_valid_r <= 1'b1;
                ptr_r       <= ptr_next_s;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_r;
    assign out_chan  = out_chan_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_mux_rr_pipe.sv
// Bench for mux_rr_pipe: three instances (N=2, N=4, N=3) driven together, checked
// against a queue-free behavioural model of grant, output register and rr pointer.
module tb_mux_rr_pipe;

    logic        clk;
    logic        rst;
    logic        mode_a  [3];
    logic [3:0]  sel_a   [3];
    logic [15:0] valid_a [3];
    logic [4:0]  data_a  [3][16];
    logic        ordy_a  [3];

    logic [15:0] rdy_o [3];
    logic [4:0]  od_o  [3];
    logic [1:0]  oc_o  [3];
    logic        ov_o  [3];

    logic [1:0]  rdy0;  logic [4:0] od0; logic [0:0] oc0; logic ov0;
    logic [3:0]  rdy1;  logic [4:0] od1; logic [1:0] oc1; logic ov1;
    logic [2:0]  rdy2;  logic [4:0] od2; logic [1:0] oc2; logic ov2;

    logic        e_valid [3];
    logic [4:0]  e_data  [3];
    logic [1:0]  e_chan  [3];
    int          e_ptr   [3];
    logic [15:0] e_rdy   [3];
    logic [15:0] rdy_smp [3];

    int n_checks;
    int n_fail;

    mux_rr_pipe #(.WIDTH(5), .N(2), .SEL_W(1)) u_n2 (
        .clk(clk), .rst(rst),
        .in_data({data_a[0][1], data_a[0][0]}), .in_valid(valid_a[0][1:0]), .in_ready(rdy0),
        .mode(mode_a[0]), .sel(sel_a[0][0:0]),
        .out_data(od0), .out_chan(oc0), .out_valid(ov0), .out_ready(ordy_a[0])
    );

    mux_rr_pipe #(.WIDTH(5), .N(4), .SEL_W(2)) u_n4 (
        .clk(clk), .rst(rst),
        .in_data({data_a[1][3], data_a[1][2], data_a[1][1], data_a[1][0]}),
        .in_valid(valid_a[1][3:0]), .in_ready(rdy1),
        .mode(mode_a[1]), .sel(sel_a[1][1:0]),
        .out_data(od1), .out_chan(oc1), .out_valid(ov1), .out_ready(ordy_a[1])
    );

    mux_rr_pipe #(.WIDTH(5), .N(3), .SEL_W(2)) u_n3 (
        .clk(clk), .rst(rst),
        .in_data({data_a[2][2], data_a[2][1], data_a[2][0]}),
        .in_valid(valid_a[2][2:0]), .in_ready(rdy2),
        .mode(mode_a[2]), .sel(sel_a[2][1:0]),
        .out_data(od2), .out_chan(oc2), .out_valid(ov2), .out_ready(ordy_a[2])
    );

    assign rdy_o[0] = {14'd0, rdy0};
    assign rdy_o[1] = {12'd0, rdy1};
    assign rdy_o[2] = {13'd0, rdy2};
    assign od_o[0] = od0;
    assign od_o[1] = od1;
    assign od_o[2] = od2;
    assign oc_o[0] = {1'b0, oc0};
    assign oc_o[1] = oc1;
    assign oc_o[2] = oc2;
    assign ov_o[0] = ov0;
    assign ov_o[1] = ov1;
    assign ov_o[2] = ov2;

    always #5 clk = ~clk;

    function automatic int n_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 4 : 3);
    endfunction

    // Reference grant: channel index, or -1 when nothing is granted.
    function automatic int model_grant(input int k);
        int n;
        int s;
        n = n_of(k);
        s = (k == 0) ? int'(sel_a[k][0]) : int'(sel_a[k][1:0]);
        if (!mode_a[k]) begin
            if (s < n && valid_a[k][s]) return s;
            return -1;
        end
        for (int off = 0; off < n; off++) begin
            int j;
            j = (e_ptr[k] + off) % n;
            if (valid_a[k][j]) return j;
        end
        return -1;
    endfunction

    // One clock: predict ready before the edge, sample DUT ready, then advance the model.
    task automatic tick();
        int  g  [3];
        bit  ld [3];
        #1;
        for (int k = 0; k < 3; k++) begin
            g[k]       = model_grant(k);
            ld[k]      = !e_valid[k] || ordy_a[k];
            e_rdy[k]   = (!rst && ld[k] && g[k] >= 0) ? (16'd1 << g[k]) : 16'd0;
            rdy_smp[k] = rdy_o[k];
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                e_valid[k] = 1'b0; e_data[k] = 5'd0; e_chan[k] = 2'd0; e_ptr[k] = 0;
            end else if (ld[k]) begin
                if (g[k] >= 0) begin
                    e_data[k]  = data_a[k][g[k]];
                    e_chan[k]  = 2'(g[k]);
                    e_valid[k] = 1'b1;
                    e_ptr[k]   = (g[k] + 1) % n_of(k);
                end else begin
                    e_valid[k] = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        for (int k = 0; k < 3; k++) begin
            mode_a[k] = 1'b0; sel_a[k] = 4'd0; valid_a[k] = 16'd0; ordy_a[k] = 1'b1;
            for (int i = 0; i < 16; i++) data_a[k][i] = 5'd0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        valid_a[0] = 16'h0003; valid_a[1] = 16'h000F; valid_a[2] = 16'h0007;
        for (int c = 0; c < 2; c++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (rdy_smp[k] !== 16'd0 || ov_o[k] !== 1'b0 || od_o[k] !== 5'd0 || oc_o[k] !== 2'd0) begin
                    n_fail++;
                    $display("FAIL reset inst%0d: ready=%h valid=%b data=%h chan=%0d, expected all zero",
                             k, rdy_smp[k], ov_o[k], od_o[k], oc_o[k]);
                end
            end
        end
        idle();
        rst = 1'b0;
    endtask

    task automatic test_select();
        mode_a[0] = 1'b0; sel_a[0] = 4'd1; valid_a[0] = 16'h0003; ordy_a[0] = 1'b1;
        data_a[0][0] = 5'h15; data_a[0][1] = 5'h0A;
        tick();
        n_checks++;
        if (rdy_smp[0] !== 16'h0002 || od_o[0] !== 5'h0A || oc_o[0] !== 2'd1 || ov_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL select1: ready=%h data=%h chan=%0d valid=%b, expected 0002 0a 1 1",
                     rdy_smp[0], od_o[0], oc_o[0], ov_o[0]);
        end
        sel_a[0] = 4'd0;
        tick();
        n_checks++;
        if (od_o[0] !== 5'h15 || oc_o[0] !== 2'd0 || ov_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL select0: data=%h chan=%0d valid=%b, expected 15 0 1", od_o[0], oc_o[0], ov_o[0]);
        end
        sel_a[0] = 4'd1;
        tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (rdy_smp[0] !== 16'd0 || ov_o[0] !== 1'b0 || od_o[0] !== 5'd0 || oc_o[0] !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_reset: ready=%h valid=%b data=%h chan=%0d, expected 0 0 00 0",
                     rdy_smp[0], ov_o[0], od_o[0], oc_o[0]);
        end
        rst = 1'b0;
        mode_a[0] = 1'b1;
        tick();
        n_checks++;
        if (oc_o[0] !== 2'd0 || od_o[0] !== 5'h15 || ov_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_after_reset: chan=%0d data=%h valid=%b, expected 0 15 1", oc_o[0], od_o[0], ov_o[0]);
        end
        idle();
        tick();
    endtask

    task automatic test_rr_full();
        mode_a[1] = 1'b1; valid_a[1] = 16'h000F; ordy_a[1] = 1'b1;
        for (int i = 0; i < 4; i++) data_a[1][i] = 5'(i + 1);
        for (int c = 0; c < 8; c++) begin
            tick();
            n_checks++;
            if (ov_o[1] !== 1'b1 || oc_o[1] !== 2'(c % 4) || od_o[1] !== 5'((c % 4) + 1)) begin
                n_fail++;
                $display("FAIL rr_full c%0d: valid=%b chan=%0d data=%h, expected 1 %0d %0d",
                         c, ov_o[1], oc_o[1], od_o[1], c % 4, (c % 4) + 1);
            end
        end
    endtask

    task automatic test_rr_sparse();
        int exp_c [6] = '{1, 3, 1, 3, 1, 1};
        for (int c = 0; c < 6; c++) begin
            valid_a[1] = (c < 4) ? 16'h000A : 16'h0002;
            tick();
            n_checks++;
            if (ov_o[1] !== 1'b1 || oc_o[1] !== 2'(exp_c[c]) || od_o[1] !== 5'(exp_c[c] + 1)) begin
                n_fail++;
                $display("FAIL rr_sparse c%0d: valid=%b chan=%0d data=%h, expected 1 %0d",
                         c, ov_o[1], oc_o[1], od_o[1], exp_c[c]);
            end
        end
        valid_a[1] = 16'd0;
        tick();
        n_checks++;
        if (ov_o[1] !== 1'b0 || rdy_smp[1] !== 16'd0) begin
            n_fail++;
            $display("FAIL rr_empty: valid=%b ready=%h, expected 0 0", ov_o[1], rdy_smp[1]);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        mode_a[0] = 1'b0; sel_a[0] = 4'd1; valid_a[0] = 16'h0003; ordy_a[0] = 1'b1;
        data_a[0][1] = 5'h0A;
        tick();
        ordy_a[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            data_a[0][0] = 5'($urandom); data_a[0][1] = 5'($urandom);
            sel_a[0] = 4'($urandom_range(0, 1));
            tick();
            n_checks++;
            if (od_o[0] !== 5'h0A || ov_o[0] !== 1'b1 || rdy_smp[0] !== 16'd0) begin
                n_fail++;
                $display("FAIL stall c%0d: data=%h valid=%b ready=%h, expected 0a 1 0",
                         c, od_o[0], ov_o[0], rdy_smp[0]);
            end
        end
        ordy_a[0] = 1'b1; sel_a[0] = 4'd1; data_a[0][1] = 5'h07;
        tick();
        n_checks++;
        if (od_o[0] !== 5'h07 || ov_o[0] !== 1'b1 || rdy_smp[0] !== 16'h0002) begin
            n_fail++;
            $display("FAIL drain_refill: data=%h valid=%b ready=%h, expected 07 1 0002",
                     od_o[0], ov_o[0], rdy_smp[0]);
        end
        idle();
        tick();
    endtask

    task automatic test_sel_range();
        mode_a[2] = 1'b0; sel_a[2] = 4'd3; valid_a[2] = 16'h0007; ordy_a[2] = 1'b1;
        for (int i = 0; i < 3; i++) data_a[2][i] = 5'(5'h10 + i);
        tick();
        n_checks++;
        if (rdy_smp[2] !== 16'd0 || ov_o[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL sel_oob: ready=%h valid=%b, expected 0 0", rdy_smp[2], ov_o[2]);
        end
        sel_a[2] = 4'd2; valid_a[2] = 16'h0003;
        tick();
        n_checks++;
        if (rdy_smp[2] !== 16'd0 || ov_o[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL sel_invalid: ready=%h valid=%b, expected 0 0", rdy_smp[2], ov_o[2]);
        end
        valid_a[2] = 16'h0007;
        tick();
        n_checks++;
        if (rdy_smp[2] !== 16'h0004 || oc_o[2] !== 2'd2 || od_o[2] !== 5'h12) begin
            n_fail++;
            $display("FAIL sel_last: ready=%h chan=%0d data=%h, expected 0004 2 12", rdy_smp[2], oc_o[2], od_o[2]);
        end
        mode_a[2] = 1'b1;
        tick();
        n_checks++;
        if (oc_o[2] !== 2'd0 || od_o[2] !== 5'h10 || ov_o[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL mode_switch: chan=%0d data=%h valid=%b, expected 0 10 1", oc_o[2], od_o[2], ov_o[2]);
        end
        idle();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 39) == 0);
            for (int k = 0; k < 3; k++) begin
                mode_a[k]  = 1'($urandom);
                sel_a[k]   = 4'($urandom_range(0, 3));
                valid_a[k] = 16'($urandom);
                ordy_a[k]  = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < 4; i++) data_a[k][i] = 5'($urandom);
            end
            tick();
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (rdy_smp[k] !== e_rdy[k] || ov_o[k] !== e_valid[k] || od_o[k] !== e_data[k] || oc_o[k] !== e_chan[k]) begin
                    n_fail++;
                    $display("FAIL random c%0d inst%0d: ready=%h valid=%b data=%h chan=%0d, expected %h %b %h %0d",
                             c, k, rdy_smp[k], ov_o[k], od_o[k], oc_o[k], e_rdy[k], e_valid[k], e_data[k], e_chan[k]);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        n_checks = 0;
        n_fail = 0;
        for (int k = 0; k < 3; k++) begin
            e_valid[k] = 1'b0; e_data[k] = 5'd0; e_chan[k] = 2'd0; e_ptr[k] = 0;
        end
        idle();
        test_reset();
        test_select();
        test_rr_full();
        test_rr_sparse();
        test_back_to_back();
        test_sel_range();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_rr_pipe.md
Name: mux_rr_pipe

Overview:
- Parametrised successor to the datapath's fixed 2:1 select muxes.
- An N-channel, WIDTH-bit registered multiplexer with per-channel valid/ready handshaking.
- Two modes: explicit select, as used for register-destination and ALU-source selection, or round-robin arbitration among valid channels.
- Sits between producer stages and a single consumer in the datapath. It gives one registered output stage with full throughput and backpressure.

Parameters:
- WIDTH, 5, data bits per channel.
- N, 2, number of input channels; legal range 2..16.
- SEL_W, 1, select/channel-index width; must satisfy 2^SEL_W >= N.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  N*WIDTH  flattened inputs; channel i at bits [i*WIDTH +: WIDTH].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready; combinational, at most one bit high.
- mode  in  1  0 = explicit select via sel; 1 = round-robin.
- sel  in  SEL_W  channel index used when mode=0.
- out_data  out  WIDTH  registered selected data.
- out_chan  out  SEL_W  registered index of the channel that supplied out_data.
- out_valid  out  1  output register holds valid data.
- out_ready  in  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (rst=1 at a clock edge) clears state: out_valid=0, out_data=0, out_chan=0, rr pointer ptr=0.
- While rst=1, in_ready=0 on all channels. Reset mid-transfer drops any held output; no partial state survives.
- load = !out_valid || out_ready, meaning the output register is free or draining this cycle.
- Grant, mode=0: g=sel if sel<N and in_valid[sel]=1. Otherwise no grant; sel>=N never grants.
- Grant, mode=1: g is the first i with in_valid[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1. If no channel is valid, there is no grant.
- in_ready[i] = !rst && load && grant exists && g==i. A transfer occurs when in_valid[g] && in_ready[g].
- On transfer at the edge:
  - out_data <= channel g data; out_chan <= g; out_valid <= 1.
  - ptr <= (g==N-1) ? 0 : g+1. ptr updates in both modes, so switching to mode=1 continues fairly after the last grant.
- load=1 with no grant: out_valid <= 0. out_data and out_chan hold their last values (don't-care to consumer).
- load=0 (out_valid=1, out_ready=0): out_data, out_chan, out_valid and ptr all hold. Changes on mode, sel or in_data have no effect until load.
- Latency: 1 cycle from transfer to out_valid. Throughput: one transfer per cycle when out_ready stays 1.
- Simultaneous drain and refill (out_valid=1, out_ready=1, grant present): the new data replaces the old in the same edge, with no bubble.
- Producers must hold in_data/in_valid stable until accepted. The block does not check this.
- mode and sel are sampled combinationally in the grant cycle only; no registered copy exists.

Test Plan:
1. Defaults (W=5, N=2), mode=0, sel=1, in_data={5'h0A,5'h15}, in_valid=2'b11, out_ready=1 -> in_ready=2'b10; next cycle out_data=5'h0A, out_chan=1, out_valid=1. Then sel=0 -> out_data=5'h15, out_chan=0.
2. Reset: drive rst=1 for one cycle while out_valid=1 and out_data=5'h0A -> after the edge out_valid=0, out_data=0, out_chan=0; in_ready=0 during rst; first round-robin grant afterwards goes to channel 0.
3. N=4, SEL_W=2, mode=1, all in_valid=1, out_ready=1, data[i]=i+1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3 and out_data 1,2,3,4,1,2,3,4, with no bubble cycles.
4. N=4, mode=1, in_valid=4'b1010, ptr=0 -> grants 1,3,1,3. Then drop in_valid[3] -> grants continue 1,1. All-zero in_valid -> out_valid falls to 0 next cycle.
5. Backpressure: out_valid=1 with out_data=5'h0A, out_ready=0 held for 3 cycles while in_data changes -> out_data stays 5'h0A, in_ready=0; out_ready=1 -> new data loads on that edge with no bubble.
6. N=3, SEL_W=2, mode=0, sel=3 with all valid -> in_ready=0 and out_valid goes 0. sel=2 with in_valid[2]=0 -> no grant. Then mode switch to 1 after a grant of channel 2 -> next grant starts at channel 0.
